// File: rtl/a_rf_loader.sv
// Write-side sequencer for the DSP slice A-operand shift register file:
// shifts N streamed words in, then replays R read passes oldest-first.
module a_rf_loader #(
    parameter int RF_DEPTH = 8,
    parameter int AW       = 3,
    parameter int DW       = 30
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CFG_VALID,
    input  logic [3:0]    CFG_COUNT,
    input  logic [3:0]    CFG_REUSE,
    input  logic          CFG_MDR,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    output logic [DW-1:0] A,
    output logic          RF_load,
    output logic [AW-1:0] A_addr,
    output logic          MDR,
    output logic          RD_VALID,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        READ,
        FIN
    } state_t;

    state_t        state;
    logic [3:0]    n_q;
    logic [3:0]    r_q;
    logic          mdr_q;
    logic [3:0]    word_cnt;
    logic [3:0]    pass_cnt;

    logic          cfg_bad;
    logic          s_hs;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] addr_step;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cfg_bad    = 1'b0;
        s_hs       = 1'b0;
        start_addr = '0;
        addr_step  = AW'(1);
        cfg_bad    = (CFG_COUNT == 4'd0) || (CFG_COUNT > 4'(RF_DEPTH)) ||
                     (CFG_MDR && CFG_COUNT[0]);
        s_hs       = S_VALID && S_READY;
        // Oldest word sits at N-1; in MDR mode reads address the low entry of each pair.
        start_addr = mdr_q ? AW'(n_q - 4'd2) : AW'(n_q - 4'd1);
        addr_step  = mdr_q ? AW'(2) : AW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            n_q      <= '0;
            r_q      <= '0;
            mdr_q    <= 1'b0;
            word_cnt <= '0;
            pass_cnt <= '0;
            A        <= '0;
            RF_load  <= 1'b0;
            A_addr   <= '0;
            MDR      <= 1'b0;
            RD_VALID <= 1'b0;
            S_READY  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            RF_load <= 1'b0;
            ERR     <= 1'b0;
            DONE    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (CFG_VALID) begin
                        n_q      <= CFG_COUNT;
                        r_q      <= CFG_REUSE;
                        mdr_q    <= CFG_MDR;
                        word_cnt <= '0;
                        pass_cnt <= '0;
                        if (cfg_bad) begin
                            ERR <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            S_READY <= 1'b1;
                            BUSY    <= 1'b1;
                            MDR     <= CFG_MDR;
                        end
                    end
                end
                LOAD: begin
                    if (s_hs) begin
                        A        <= S_DATA;
                        RF_load  <= 1'b1;
                        word_cnt <= word_cnt + 4'd1;
                        if (word_cnt == n_q - 4'd1) begin
                            state   <= SETTLE;
                            S_READY <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    if (r_q != 4'd0) begin
                        state    <= READ;
                        RD_VALID <= 1'b1;
                        A_addr   <= start_addr;
                    end else begin
                        state <= FIN;
                        DONE  <= 1'b1;
                    end
                end
                READ: begin
                    if (A_addr == '0) begin
                        pass_cnt <= pass_cnt + 4'd1;
                        if (pass_cnt == r_q - 4'd1) begin
                            state    <= FIN;
                            RD_VALID <= 1'b0;
                            A_addr   <= '0;
                            DONE     <= 1'b1;
                        end else begin
                            A_addr <= start_addr;
                        end
                    end else begin
                        A_addr <= A_addr - addr_step;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    MDR   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_rf_loader.sv
// Directed bench for a_rf_loader: table of job descriptors plus hand-written
// reset-abort and held-CFG_VALID sequences.
module tb_a_rf_loader;

    localparam int DW = 30;
    localparam int AW = 3;

    logic          CLK;
    logic          RSTN;
    logic          CFG_VALID;
    logic [3:0]    CFG_COUNT;
    logic [3:0]    CFG_REUSE;
    logic          CFG_MDR;
    logic          S_VALID;
    logic          S_READY;
    logic [DW-1:0] S_DATA;
    logic [DW-1:0] A;
    logic          RF_load;
    logic [AW-1:0] A_addr;
    logic          MDR;
    logic          RD_VALID;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    int total = 0;
    int bad   = 0;

    a_rf_loader dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .CFG_VALID(CFG_VALID),
        .CFG_COUNT(CFG_COUNT),
        .CFG_REUSE(CFG_REUSE),
        .CFG_MDR  (CFG_MDR),
        .S_VALID  (S_VALID),
        .S_READY  (S_READY),
        .S_DATA   (S_DATA),
        .A        (A),
        .RF_load  (RF_load),
        .A_addr   (A_addr),
        .MDR      (MDR),
        .RD_VALID (RD_VALID),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: got still_running want finished");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic [3:0] n;
        logic [3:0] r;
        logic       mdr;
        logic       toggle;
        logic       exp_err;
        int         exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " A"}, 32'(A), 0);
        check({tag, " RF_load"}, 32'(RF_load), 0);
        check({tag, " A_addr"}, 32'(A_addr), 0);
        check({tag, " MDR"}, 32'(MDR), 0);
        check({tag, " RD_VALID"}, 32'(RD_VALID), 0);
        check({tag, " S_READY"}, 32'(S_READY), 0);
        check({tag, " BUSY"}, 32'(BUSY), 0);
        check({tag, " DONE"}, 32'(DONE), 0);
        check({tag, " ERR"}, 32'(ERR), 0);
    endtask

    function automatic logic [DW-1:0] word_of(input int tag, input int k);
        return DW'(32'h0010_0000 * tag + 32'h11 * (k + 1));
    endfunction

    // Runs one legal job and checks every cycle against the expected sequence.
    task automatic run_job(input int tag, input logic [3:0] n, input logic [3:0] r,
                           input logic mdr, input logic toggle, input logic hold,
                           input logic started, input int exp_rd);
        int rd_seen;
        int len;
        logic [DW-1:0] prev;
        rd_seen = 0;
        if (!started) begin
            CFG_VALID = 1'b1;
            CFG_COUNT = n;
            CFG_REUSE = r;
            CFG_MDR   = mdr;
            step();
        end
        CFG_VALID = hold;
        check("cfg BUSY", 32'(BUSY), 1);
        check("cfg S_READY", 32'(S_READY), 1);
        check("cfg MDR", 32'(MDR), 32'(mdr));
        check("cfg RF_load", 32'(RF_load), 0);
        check("cfg ERR", 32'(ERR), 0);
        prev = A;
        for (int k = 0; k < int'(n); k++) begin
            if (toggle) begin
                S_VALID = 1'b0;
                step();
                check("gap RF_load", 32'(RF_load), 0);
                check("gap S_READY", 32'(S_READY), 1);
                check("gap A hold", 32'(A), 32'(prev));
            end
            S_VALID = 1'b1;
            S_DATA  = word_of(tag, k);
            step();
            S_VALID = 1'b0;
            check("load RF_load", 32'(RF_load), 1);
            check("load A", 32'(A), 32'(word_of(tag, k)));
            check("load S_READY", 32'(S_READY), (k < int'(n) - 1) ? 1 : 0);
            check("load RD_VALID", 32'(RD_VALID), 0);
            check("load MDR", 32'(MDR), 32'(mdr));
            prev = word_of(tag, k);
        end
        len = mdr ? int'(n) / 2 : int'(n);
        for (int p = 0; p < int'(r); p++) begin
            for (int i = 0; i < len; i++) begin
                step();
                rd_seen += int'(RD_VALID);
                check("read A_addr", 32'(A_addr), mdr ? 32'(int'(n) - 2 - 2 * i) : 32'(int'(n) - 1 - i));
                check("read RF_load", 32'(RF_load), 0);
                check("read DONE", 32'(DONE), 0);
                check("read MDR", 32'(MDR), 32'(mdr));
                check("read S_READY", 32'(S_READY), 0);
            end
        end
        step();
        check("fin DONE", 32'(DONE), 1);
        check("fin RD_VALID", 32'(RD_VALID), 0);
        check("fin A_addr", 32'(A_addr), 0);
        check("fin BUSY", 32'(BUSY), 1);
        check("fin MDR", 32'(MDR), 32'(mdr));
        check("read count", 32'(rd_seen), 32'(exp_rd));
        step();
        check("idle DONE", 32'(DONE), 0);
        check("idle BUSY", 32'(BUSY), 0);
        check("idle MDR", 32'(MDR), 0);
        check("idle RD_VALID", 32'(RD_VALID), 0);
    endtask

    task automatic run_illegal(input logic [3:0] n, input logic [3:0] r, input logic mdr);
        CFG_VALID = 1'b1;
        CFG_COUNT = n;
        CFG_REUSE = r;
        CFG_MDR   = mdr;
        step();
        CFG_VALID = 1'b0;
        check("rej ERR", 32'(ERR), 1);
        check("rej BUSY", 32'(BUSY), 0);
        check("rej S_READY", 32'(S_READY), 0);
        step();
        check("rej ERR clear", 32'(ERR), 0);
        check("rej BUSY idle", 32'(BUSY), 0);
        check("rej S_READY idle", 32'(S_READY), 0);
    endtask

    initial begin
        vec_t vecs[9];
        vecs[0] = '{n: 4'd3, r: 4'd1, mdr: 1'b0, toggle: 1'b0, exp_err: 1'b0, exp_rd: 3};
        vecs[1] = '{n: 4'd4, r: 4'd2, mdr: 1'b1, toggle: 1'b0, exp_err: 1'b0, exp_rd: 4};
        vecs[2] = '{n: 4'd8, r: 4'd0, mdr: 1'b0, toggle: 1'b1, exp_err: 1'b0, exp_rd: 0};
        vecs[3] = '{n: 4'd0, r: 4'd1, mdr: 1'b0, toggle: 1'b0, exp_err: 1'b1, exp_rd: 0};
        vecs[4] = '{n: 4'd9, r: 4'd1, mdr: 1'b0, toggle: 1'b0, exp_err: 1'b1, exp_rd: 0};
        vecs[5] = '{n: 4'd3, r: 4'd1, mdr: 1'b1, toggle: 1'b0, exp_err: 1'b1, exp_rd: 0};
        vecs[6] = '{n: 4'd1, r: 4'd2, mdr: 1'b0, toggle: 1'b0, exp_err: 1'b0, exp_rd: 2};
        vecs[7] = '{n: 4'd8, r: 4'd1, mdr: 1'b1, toggle: 1'b0, exp_err: 1'b0, exp_rd: 4};
        vecs[8] = '{n: 4'd2, r: 4'd3, mdr: 1'b1, toggle: 1'b0, exp_err: 1'b0, exp_rd: 3};

        RSTN      = 1'b0;
        CFG_VALID = 1'b0;
        CFG_COUNT = '0;
        CFG_REUSE = '0;
        CFG_MDR   = 1'b0;
        S_VALID   = 1'b0;
        S_DATA    = '0;
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RSTN = 1'b1;
        step();
        check("post-reset BUSY", 32'(BUSY), 0);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].exp_err)
                run_illegal(vecs[v].n, vecs[v].r, vecs[v].mdr);
            else
                run_job(v + 1, vecs[v].n, vecs[v].r, vecs[v].mdr, vecs[v].toggle,
                        1'b0, 1'b0, vecs[v].exp_rd);
        end

        // Reset abort during READ of an N=5, R=3 job.
        CFG_VALID = 1'b1;
        CFG_COUNT = 4'd5;
        CFG_REUSE = 4'd3;
        CFG_MDR   = 1'b0;
        step();
        CFG_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            S_VALID = 1'b1;
            S_DATA  = word_of(12, k);
            step();
        end
        S_VALID = 1'b0;
        step();
        step();
        check("abort pre A_addr", 32'(A_addr), 3);
        check("abort pre RD_VALID", 32'(RD_VALID), 1);
        #2;
        RSTN = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge CLK);
        RSTN = 1'b1;
        step();
        check("abort idle BUSY", 32'(BUSY), 0);
        run_job(13, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // CFG_VALID held through a job: exactly one job, the next starts after DONE.
        run_job(14, 4'd2, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        step();
        run_job(15, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
